// File: rtl/pwm_bank_if.sv
// -----------------------------------------------------------------------------
// pwm_bank_if
//   Request/rvalid device bus shared by the simple peripherals of the system.
//   master : drives a single-cycle request (req/addr/we/be/wdata)
//   slave  : answers one cycle later with rvalid and, for reads, rdata
// -----------------------------------------------------------------------------
interface pwm_bank_if;
    logic        device_req_i;
    logic [31:0] device_addr_i;
    logic        device_we_i;
    logic [3:0]  device_be_i;
    logic [31:0] device_wdata_i;
    logic        device_rvalid_o;
    logic [31:0] device_rdata_o;

    modport master (
        output device_req_i, device_addr_i, device_we_i, device_be_i, device_wdata_i,
        input  device_rvalid_o, device_rdata_o
    );

    modport slave (
        input  device_req_i, device_addr_i, device_we_i, device_be_i, device_wdata_i,
        output device_rvalid_o, device_rdata_o
    );
endinterface

// File: rtl/pwm_bank.sv
// -----------------------------------------------------------------------------
// pwm_bank
//   Bus-programmable bank of NumChannels PWM generators with shadowed
//   pulse/max registers that are copied to the active set at each channel's
//   counter wrap (or on the next cycle while the bank is disabled).
//
//   Ports
//     clk_i   : system clock
//     rst_ni  : asynchronous active-low reset
//     bus     : device bus slave (req/addr/we/be/wdata -> rvalid/rdata)
//     pwm_o   : registered PWM outputs, one per channel
//
//   Word map (byte offsets)
//     0x000 CTRL   bit0 EN, bit1 UPD (write 1 = request, read = any pending),
//                  bit2 INV
//     0x004 INFO   [7:0] NumChannels, [15:8] CtrWidth (read-only)
//     0x100+8*i    PULSE_i shadow
//     0x104+8*i    MAX_i   shadow
// -----------------------------------------------------------------------------
module pwm_bank #(
    parameter int NumChannels = 12,
    parameter int CtrWidth    = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    pwm_bank_if.slave              bus,
    output logic [NumChannels-1:0] pwm_o
);
    typedef logic [CtrWidth-1:0] cval_t;

    localparam logic [9:0] CtrlWord = 10'h000;
    localparam logic [9:0] InfoWord = 10'h001;

    // Control state
    logic en_q, en_d;
    logic inv_q, inv_d;

    // Per-channel state
    cval_t                  pulse_s_q [NumChannels];
    cval_t                  pulse_s_d [NumChannels];
    cval_t                  max_s_q   [NumChannels];
    cval_t                  max_s_d   [NumChannels];
    cval_t                  pulse_a_q [NumChannels];
    cval_t                  pulse_a_d [NumChannels];
    cval_t                  max_a_q   [NumChannels];
    cval_t                  max_a_d   [NumChannels];
    cval_t                  ctr_q     [NumChannels];
    cval_t                  ctr_d     [NumChannels];
    logic [NumChannels-1:0] pend_q, pend_d;
    logic [NumChannels-1:0] pwm_q, pwm_d;

    // Bus response
    logic        rvalid_q;
    logic [31:0] rdata_q, rdata_d;

    // Address decode: word index [11:2]; channel window 0x100..0x1FF holds
    // 32 channel slots of two words each.
    logic [9:0] word;
    logic       chan_region;
    logic [4:0] ch_idx;
    logic       is_max;
    logic       wr, rd, ctrl_wr, upd_wr;
    logic       unused_addr;

    assign word        = bus.device_addr_i[11:2];
    assign chan_region = (word[9:6] == 4'h1);
    assign ch_idx      = word[5:1];
    assign is_max      = word[0];
    assign wr          = bus.device_req_i & bus.device_we_i;
    assign rd          = bus.device_req_i & ~bus.device_we_i;
    assign ctrl_wr     = wr && (word == CtrlWord) && bus.device_be_i[0];
    assign upd_wr      = ctrl_wr && bus.device_wdata_i[1];
    assign unused_addr = ^{bus.device_addr_i[31:12], bus.device_addr_i[1:0]};

    // Byte-enable merge into a CtrWidth-bit register; bits at or above
    // CtrWidth are dropped.
    function automatic cval_t merge_be(cval_t old, logic [31:0] wdata, logic [3:0] be);
        logic [31:0] merged;
        merged = 32'(old);
        for (int b = 0; b < 4; b++) begin
            if (be[b]) merged[8*b +: 8] = wdata[8*b +: 8];
        end
        return merged[CtrWidth-1:0];
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        en_d    = en_q;
        inv_d   = inv_q;
        pend_d  = pend_q;
        pwm_d   = pwm_q;
        rdata_d = '0;

        if (ctrl_wr) begin
            en_d  = bus.device_wdata_i[0];
            inv_d = bus.device_wdata_i[2];
        end

        for (int i = 0; i < NumChannels; i++) begin
            logic wrap;
            logic apply;

            pulse_s_d[i] = pulse_s_q[i];
            max_s_d[i]   = max_s_q[i];
            pulse_a_d[i] = pulse_a_q[i];
            max_a_d[i]   = max_a_q[i];

            wrap  = en_q && (ctr_q[i] == max_a_q[i]);
            // Disabled channels apply a pending update straight away.
            apply = pend_q[i] && (wrap || !en_q);

            // Apply copies the pre-write shadow; a UPD arriving in the same
            // cycle uses pend_q, so it waits for the following wrap.
            if (apply) begin
                pulse_a_d[i] = pulse_s_q[i];
                max_a_d[i]   = max_s_q[i];
            end
            pend_d[i] = (pend_q[i] & ~apply) | upd_wr;

            ctr_d[i] = (!en_q || wrap) ? '0 : ctr_q[i] + cval_t'(1);
            pwm_d[i] = en_q ? ((ctr_q[i] < pulse_a_q[i]) ^ inv_q) : inv_q;

            if (wr && chan_region && (ch_idx == 5'(i))) begin
                if (is_max) max_s_d[i]   = merge_be(max_s_q[i], bus.device_wdata_i, bus.device_be_i);
                else        pulse_s_d[i] = merge_be(pulse_s_q[i], bus.device_wdata_i, bus.device_be_i);
            end

            if (rd && chan_region && (ch_idx == 5'(i))) begin
                rdata_d = is_max ? 32'(max_s_q[i]) : 32'(pulse_s_q[i]);
            end
        end

        if (rd && (word == CtrlWord)) rdata_d = {29'd0, inv_q, |pend_q, en_q};
        if (rd && (word == InfoWord)) rdata_d = {16'd0, 8'(CtrWidth), 8'(NumChannels)};
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q     <= 1'b0;
            inv_q    <= 1'b0;
            pend_q   <= '0;
            pwm_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            // NOTE: the per-channel arrays are real state with defined reset
            // values (max = all ones), so they are reset like any flop.
            for (int i = 0; i < NumChannels; i++) begin
                pulse_s_q[i] <= '0;
                max_s_q[i]   <= '1;
                pulse_a_q[i] <= '0;
                max_a_q[i]   <= '1;
                ctr_q[i]     <= '0;
            end
        end else begin
            en_q     <= en_d;
            inv_q    <= inv_d;
            pend_q   <= pend_d;
            pwm_q    <= pwm_d;
            rvalid_q <= bus.device_req_i;
            rdata_q  <= rdata_d;
            for (int i = 0; i < NumChannels; i++) begin
                pulse_s_q[i] <= pulse_s_d[i];
                max_s_q[i]   <= max_s_d[i];
                pulse_a_q[i] <= pulse_a_d[i];
                max_a_q[i]   <= max_a_d[i];
                ctr_q[i]     <= ctr_d[i];
            end
        end
    end

    assign pwm_o               = pwm_q;
    assign bus.device_rvalid_o = rvalid_q;
    assign bus.device_rdata_o  = rdata_q;

endmodule

// File: tb/tb_pwm_bank.sv
// -----------------------------------------------------------------------------
// tb_pwm_bank
//   Directed bench for pwm_bank with default parameters (12 channels, 8-bit).
//   Read expectations go into a queue when a request is issued and are popped
//   when the response arrives. PWM expectations come from a small phase model
//   driven by an edge counter.
// -----------------------------------------------------------------------------
module tb_pwm_bank;
    localparam int NCH = 12;
    localparam int BIG = 1 << 30;

    logic           clk;
    logic           rst_n;
    logic [NCH-1:0] pwm;

    pwm_bank_if bus ();

    pwm_bank dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave),
        .pwm_o  (pwm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedge counter; read at negedges it equals the count of the last edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q [$];

    // Channel 0 model: counter restarted at edge t_en with period 10; the
    // duty changes from 3 to 7 at edge c_w; outputs invert from edge c_inv.
    int t_en  = 0;
    int c_w   = BIG;
    int c_inv = BIG;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        @(negedge clk);
        bus.device_req_i   = 1'b1;
        bus.device_we_i    = 1'b1;
        bus.device_addr_i  = addr;
        bus.device_wdata_i = data;
        bus.device_be_i    = be;
        @(negedge clk);
        bus.device_req_i   = 1'b0;
        bus.device_we_i    = 1'b0;
        check("wr_rvalid", 32'(bus.device_rvalid_o), 32'd1);
    endtask

    task automatic bus_rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] e;
        @(negedge clk);
        bus.device_req_i  = 1'b1;
        bus.device_we_i   = 1'b0;
        bus.device_addr_i = addr;
        exp_q.push_back(exp);
        @(negedge clk);
        bus.device_req_i  = 1'b0;
        check({tag, "_rvalid"}, 32'(bus.device_rvalid_o), 32'd1);
        e = exp_q.pop_front();
        check(tag, bus.device_rdata_o, e);
    endtask

    // Expected outputs after edge c: ch0 from the model, ch2 constant high,
    // all other channels constant low, everything XOR INV.
    task automatic check_pwm(input string tag);
        int          c;
        int          duty;
        logic        inv;
        logic [NCH-1:0] e;
        c    = cyc;
        duty = (c - 1 >= c_w) ? 7 : 3;
        inv  = (c - 1 >= c_inv);
        e    = {NCH{inv}};
        e[0] = (((c - 1 - t_en) % 10) < duty) ^ inv;
        e[2] = ~inv;
        check(tag, 32'(pwm), 32'(e));
    endtask

    initial begin
        int c_u;
        int c_e;

        bus.device_req_i   = 1'b0;
        bus.device_we_i    = 1'b0;
        bus.device_addr_i  = '0;
        bus.device_wdata_i = '0;
        bus.device_be_i    = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        repeat (2) begin
            @(negedge clk);
            check("rst_pwm", 32'(pwm), 32'd0);
            check("rst_rvalid", 32'(bus.device_rvalid_o), 32'd0);
            check("rst_rdata", bus.device_rdata_o, 32'd0);
        end
        bus_rd("info", 32'h004, 32'h0000_080C);
        bus_rd("max0_rst", 32'h104, 32'h0000_00FF);
        bus_rd("ctrl_rst", 32'h000, 32'h0);

        // Program ch0 3/10, ch1 pulse 0, ch2 pulse 0xFF > max 0x10
        bus_wr(32'h100, 32'd3, 4'hF);
        bus_wr(32'h104, 32'd9, 4'hF);
        bus_wr(32'h108, 32'd0, 4'hF);
        bus_wr(32'h110, 32'hFF, 4'hF);
        bus_wr(32'h114, 32'h10, 4'hF);
        bus_wr(32'h000, 32'h2, 4'hF);       // UPD while disabled: next cycle
        bus_rd("ctrl_upd_off", 32'h000, 32'h0);
        bus_rd("max2", 32'h114, 32'h10);

        // Enable and check the 3/10 waveform
        bus_wr(32'h000, 32'h1, 4'hF);
        t_en = cyc;
        repeat (25) begin
            @(negedge clk);
            check_pwm("pwm_3of10");
        end

        // Shadow write without UPD: waveform unchanged, readback new value
        bus_wr(32'h100, 32'd7, 4'hF);
        check_pwm("pwm_shadow_wr");
        bus_rd("pulse0_shadow", 32'h100, 32'd7);
        repeat (12) begin
            @(negedge clk);
            check_pwm("pwm_shadow_hold");
        end

        // UPD: 7/10 starts exactly at the next ch0 wrap
        bus_wr(32'h000, 32'h3, 4'hF);
        c_u = cyc;
        c_w = t_en + 10 * ((c_u - t_en) / 10 + 1);
        check_pwm("pwm_upd_wr");
        bus_rd("ctrl_pend", 32'h000, 32'h3);
        check_pwm("pwm_upd_rd");
        repeat (25) begin
            @(negedge clk);
            check_pwm("pwm_upd");
        end
        repeat (300) @(negedge clk);        // every channel has wrapped
        bus_rd("ctrl_pend_clr", 32'h000, 32'h1);

        // INV
        bus_wr(32'h000, 32'h5, 4'hF);
        c_inv = cyc;
        repeat (15) begin
            @(negedge clk);
            check_pwm("pwm_inv");
        end

        // Byte enables and unmapped accesses
        bus_wr(32'h118, 32'hABCD, 4'b0010);
        bus_rd("pulse3_be", 32'h118, 32'h0);
        bus_wr(32'h11C, 32'h1234, 4'b0001);
        bus_rd("max3_be", 32'h11C, 32'h34);
        bus_rd("unmapped", 32'h800, 32'h0);
        bus_wr(32'h1A0, 32'h55, 4'hF);       // channel 20
        bus_wr(32'h1A4, 32'h66, 4'hF);
        bus_rd("ch20_pulse", 32'h1A0, 32'h0);
        bus_rd("ch20_max", 32'h1A4, 32'h0);
        bus_rd("pulse0_keep", 32'h100, 32'd7);
        bus_wr(32'h004, 32'hFFFF_FFFF, 4'hF);  // INFO is read-only
        bus_rd("info_ro", 32'h004, 32'h0000_080C);
        bus_rd("ctrl_keep", 32'h000, 32'h5);
        check_pwm("pwm_after_bus");

        // Clear EN mid-period: outputs low while disabled
        bus_wr(32'h000, 32'h0, 4'hF);
        c_e = cyc;
        repeat (6) begin
            @(negedge clk);
            check("pwm_disabled", 32'(pwm), 32'd0);
        end

        // Re-enable: period restarts from 0 with the 7/10 duty
        bus_wr(32'h000, 32'h1, 4'hF);
        t_en  = cyc;
        c_w   = 0;
        c_inv = BIG;
        check("reen_gap", 32'(t_en > c_e + 1), 32'd1);
        repeat (22) begin
            @(negedge clk);
            check_pwm("pwm_reenable");
        end

        // Asynchronous reset mid-period with a read in flight
        @(negedge clk);
        bus.device_req_i  = 1'b1;
        bus.device_we_i   = 1'b0;
        bus.device_addr_i = 32'h100;
        #2 rst_n = 1'b0;
        #1;
        check("arst_pwm", 32'(pwm), 32'd0);
        check("arst_rvalid", 32'(bus.device_rvalid_o), 32'd0);
        @(negedge clk);
        bus.device_req_i = 1'b0;
        check("arst_no_resp", 32'(bus.device_rvalid_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_pwm", 32'(pwm), 32'd0);
        bus_rd("ctrl_post_rst", 32'h000, 32'h0);
        bus_rd("max0_post_rst", 32'h104, 32'hFF);
        bus_rd("pulse0_post_rst", 32'h100, 32'h0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
